// File: rtl/line_prefetcher.sv
// Double-buffered scanline prefetcher: serves pixels to a video driver from two
// line buffers while refilling the idle buffer from a word-addressed framebuffer.
module line_prefetcher #(
    parameter int bitsPerPixel          = 8,
    parameter int renderCoordinateWidth = 10,
    parameter int lineWidth             = 160,
    parameter int lineCount             = 120,
    parameter int addrWidth             = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [renderCoordinateWidth-1:0] rendX,
    input  logic [renderCoordinateWidth-1:0] rendY,
    input  logic                             valid,
    output logic [bitsPerPixel-1:0]          color,
    output logic                             mem_req,
    output logic [addrWidth-1:0]             mem_addr,
    input  logic                             mem_ack,
    input  logic [bitsPerPixel-1:0]          mem_data,
    output logic                             underflow
);

    localparam int CW = (lineWidth > 1) ? $clog2(lineWidth) : 1;
    localparam int RW = renderCoordinateWidth;

    localparam logic [CW-1:0] LAST_PIX  = CW'(lineWidth - 1);
    localparam logic [RW-1:0] LAST_LINE = RW'(lineCount - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [bitsPerPixel-1:0] buf0_q [lineWidth];
    logic [bitsPerPixel-1:0] buf1_q [lineWidth];

    logic [0:0]              state_q, state_d;
    logic                    start_q, start_d;
    logic                    valid_q, valid_d;
    logic [RW-1:0]           last_y_q, last_y_d;
    logic [RW-1:0]           next_line_q, next_line_d;
    logic                    target_q, target_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [RW-1:0]           tag0_q, tag0_d, tag1_q, tag1_d;
    logic                    tv0_q, tv0_d, tv1_q, tv1_d;
    logic [bitsPerPixel-1:0] color_q, color_d;
    logic                    underflow_q, underflow_d;

    logic          hit0, hit1, in_range;
    logic [CW-1:0] rd_idx;
    logic          trigger, next_hit, own0;
    logic [RW-1:0] next_calc;
    logic          wr0, wr1;

    // Pixel lookup path: one registered read per cycle.
    always_comb begin
        hit0     = tv0_q && (tag0_q == rendY);
        hit1     = tv1_q && (tag1_q == rendY);
        in_range = int'(rendX) < lineWidth;
        rd_idx   = rendX[CW-1:0];
        color_d  = '0;
        if (valid && in_range) begin
            if (hit0) begin
                color_d = buf0_q[rd_idx];
            end else if (hit1) begin
                color_d = buf1_q[rd_idx];
            end
        end
        underflow_d = underflow_q | (valid & ~hit0 & ~hit1);
    end

    // A falling edge of valid marks the end of a displayed line; last_y_q
    // holds the row that was active when it fell.
    always_comb begin
        valid_d   = valid;
        last_y_d  = valid ? rendY : last_y_q;
        trigger   = valid_q && !valid;
        next_calc = (last_y_q == LAST_LINE) ? '0 : last_y_q + 1'b1;
        next_hit  = (tv0_q && (tag0_q == next_calc)) || (tv1_q && (tag1_q == next_calc));
        own0      = tv0_q && (tag0_q == last_y_q);
    end

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        next_line_d = next_line_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        tag0_d      = tag0_q;
        tag1_d      = tag1_q;
        tv0_d       = tv0_q;
        tv1_d       = tv1_q;
        wr0         = 1'b0;
        wr1         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_q) begin
                    start_d     = 1'b0;
                    state_d     = FETCH;
                    next_line_d = '0;
                    target_d    = 1'b0;
                    tv0_d       = 1'b0;
                    cnt_d       = '0;
                end else if (trigger && !next_hit) begin
                    // B0 is preferred unless it holds the line on screen.
                    state_d     = FETCH;
                    next_line_d = next_calc;
                    target_d    = own0;
                    cnt_d       = '0;
                    if (own0) begin
                        tv1_d = 1'b0;
                    end else begin
                        tv0_d = 1'b0;
                    end
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    wr0   = !target_q;
                    wr1   = target_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_PIX) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (target_q) begin
                            tag1_d = next_line_q;
                            tv1_d  = 1'b1;
                        end else begin
                            tag0_d = next_line_q;
                            tv0_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            start_q     <= 1'b1;
            valid_q     <= 1'b0;
            last_y_q    <= '0;
            next_line_q <= '0;
            target_q    <= 1'b0;
            cnt_q       <= '0;
            tag0_q      <= '0;
            tag1_q      <= '0;
            tv0_q       <= 1'b0;
            tv1_q       <= 1'b0;
            color_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            valid_q     <= valid_d;
            last_y_q    <= last_y_d;
            next_line_q <= next_line_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            tag0_q      <= tag0_d;
            tag1_q      <= tag1_d;
            tv0_q       <= tv0_d;
            tv1_q       <= tv1_d;
            color_q     <= color_d;
            underflow_q <= underflow_d;
        end
    end

    // Buffer storage is not reset; writes are suppressed while rst is low.
    always_ff @(posedge clk) begin
        if (rst && wr0) begin
            buf0_q[cnt_q] <= mem_data;
        end
        if (rst && wr1) begin
            buf1_q[cnt_q] <= mem_data;
        end
    end

    assign mem_req   = (state_q == FETCH);
    assign mem_addr  = mem_req ? (addrWidth'(next_line_q) * addrWidth'(lineWidth) + addrWidth'(cnt_q))
                               : '0;
    assign color     = color_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_line_prefetcher.sv
// Randomized scoreboard bench for line_prefetcher: a line-level model predicts
// fetch address streams and returned pixels; separate monitors compare them.
module tb_line_prefetcher;

    localparam int BPP = 8;
    localparam int RW  = 10;
    localparam int LW  = 160;
    localparam int LC  = 120;
    localparam int AW  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [RW-1:0]  rendX, rendY;
    logic           valid;
    logic [BPP-1:0] color;
    logic           mem_req;
    logic [AW-1:0]  mem_addr;
    logic           mem_ack;
    logic [BPP-1:0] mem_data;
    logic           underflow;

    line_prefetcher #(
        .bitsPerPixel(BPP),
        .renderCoordinateWidth(RW),
        .lineWidth(LW),
        .lineCount(LC),
        .addrWidth(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rendX(rendX),
        .rendY(rendY),
        .valid(valid),
        .color(color),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_data(mem_data),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [BPP-1:0] word_at(input int a);
        return BPP'(((a * 29) + 7) ^ (a >> 3));
    endfunction

    assign mem_data = word_at(int'(mem_addr));

    typedef struct {
        logic [BPP-1:0] c;
        bit             u;
    } pix_t;

    // Line-level reference model: which framebuffer line each buffer holds.
    int   tag[2];
    bit   tv[2];
    bit   uf;
    int   pend_buf = -1;
    int   pend_line;
    int   exp_addr[$];
    pix_t exp_pix[$];

    int checks = 0;
    int passed = 0;
    int ack_mode = 0;   // 0: ack tied high, 1: random 0..3 wait, 2: fixed 3 wait, 3: never
    bit mon_en = 1'b0;
    int wcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit holds(input int y);
        return (tv[0] && tag[0] == y) || (tv[1] && tag[1] == y);
    endfunction

    function automatic logic [BPP-1:0] model_color(input bit v, input int x, input int y);
        if (!v || x >= LW || !holds(y)) return '0;
        return word_at(y * LW + x);
    endfunction

    task automatic start_fetch(input int b, input int line);
        tv[b]     = 1'b0;
        pend_buf  = b;
        pend_line = line;
        for (int i = 0; i < LW; i++) exp_addr.push_back(line * LW + i);
    endtask

    task automatic model_trigger(input int y);
        int nxt;
        if (pend_buf >= 0) return;
        nxt = (y == LC - 1) ? 0 : y + 1;
        if (holds(nxt)) return;
        start_fetch((tv[0] && tag[0] == y) ? 1 : 0, nxt);
    endtask

    task automatic model_complete();
        if (pend_buf >= 0) begin
            tag[pend_buf] = pend_line;
            tv[pend_buf]  = 1'b1;
            pend_buf      = -1;
        end
    endtask

    task automatic drive(input bit v, input int x, input int y);
        pix_t p;
        valid = v;
        rendX = RW'(x);
        rendY = RW'(y);
        p.c = model_color(v, x, y);
        if (v && !holds(y)) uf = 1'b1;
        p.u = uf;
        exp_pix.push_back(p);
        @(negedge clk);
    endtask

    task automatic wait_fetch(input bit v, input int y);
        int k = 0;
        while (exp_addr.size() > 0 && k < 4000) begin
            drive(v, $urandom_range(0, LW + 9), y);
            k++;
        end
        chk("fetch_done", exp_addr.size(), 0);
        repeat (3) drive(v, $urandom_range(0, LW - 1), y);
        model_complete();
        chk("req_after_fetch", mem_req, 0);
    endtask

    task automatic display_line(input int y, input int n, input int mode);
        drive(1, 5, y);
        drive(1, LW - 1, y);
        drive(1, LW, y);
        repeat (n) drive(1, $urandom_range(0, LW + 9), y);
        drive(0, 0, y);
        model_trigger(y);
        if (pend_buf >= 0) begin
            ack_mode = mode;
            wait_fetch(1, y);
            drive(0, 0, y);
            model_trigger(y);
        end
        repeat (4) drive(0, 0, y);
    endtask

    task automatic reset_release();
        tv[0] = 1'b0; tv[1] = 1'b0; uf = 1'b0; pend_buf = -1;
        exp_addr.delete();
        start_fetch(0, 0);
        ack_mode = 0;
        mon_en   = 1'b1;
        rst      = 1'b1;
    endtask

    // Memory responder and address-stream monitor.
    always @(negedge clk) begin
        case (ack_mode)
            0: mem_ack = 1'b1;
            3: mem_ack = 1'b0;
            default: begin
                if (!mem_req) begin
                    mem_ack = 1'b0;
                    wcnt = (ack_mode == 2) ? 3 : $urandom_range(0, 3);
                end else if (wcnt == 0) begin
                    mem_ack = 1'b1;
                    wcnt = (ack_mode == 2) ? 3 : $urandom_range(0, 3);
                end else begin
                    mem_ack = 1'b0;
                    wcnt--;
                end
            end
        endcase
        if (mon_en && mem_req) begin
            if (exp_addr.size() == 0) begin
                chk("spurious_req", mem_req, 0);
            end else begin
                chk("mem_addr", mem_addr, exp_addr[0]);
                if (mem_ack) void'(exp_addr.pop_front());
            end
        end
    end

    // Pixel monitor: one expectation per driven cycle, due after the next edge.
    always @(posedge clk) begin : pix_mon
        pix_t p;
        #1;
        if (exp_pix.size() > 0) begin
            p = exp_pix.pop_front();
            chk("color", color, p.c);
            chk("underflow", underflow, p.u);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b0; valid = 1'b0; rendX = '0; rendY = '0;
        repeat (3) @(negedge clk);
        chk("rst_color", color, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_underflow", underflow, 0);

        reset_release();
        wait_fetch(0, 0);

        display_line(0, 20, 1);
        display_line(1, 10, 2);
        display_line(2, 10, 1);

        // Unloaded rows set the sticky flag; the last one also triggers a fetch.
        drive(1, 3, 7);
        drive(1, 4, 118);
        drive(0, 0, 118);
        model_trigger(118);
        ack_mode = 1;
        wait_fetch(0, 118);

        display_line(119, 10, 1);
        display_line(119, 5, 1);
        display_line(0, 5, 1);

        // Abort a fetch part-way through with reset.
        drive(1, 0, 5);
        drive(0, 0, 5);
        model_trigger(5);
        ack_mode = 1;
        k = 0;
        while (exp_addr.size() > 140 && k < 500) begin
            drive(0, 0, 5);
            k++;
        end
        chk("partial_fetch", exp_addr.size() <= 140, 1);
        ack_mode = 3;
        mon_en   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_mem_req", mem_req, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_underflow", underflow, 0);
        @(negedge clk);
        chk("abort_color", color, 0);

        reset_release();
        wait_fetch(0, 0);
        repeat (10) drive(1, $urandom_range(0, LW - 1), 0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
